// File: rtl/imem_responder_if.sv
// Fetch-side bus between the IF stage and the instruction-memory responder:
// request channel, response channel, redirect flush and the preload port.
interface imem_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] req_addr;
  logic             req_valid;
  logic             req_ready;
  logic             flush;
  logic [WIDTH-1:0] rsp_instr;
  logic [WIDTH-1:0] rsp_addr;
  logic             rsp_err;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Fetch stage / bench side
  modport master (
    output req_addr, req_valid, flush, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_instr, rsp_addr, rsp_err, rsp_valid
  );

  // Memory responder side
  modport slave (
    input  req_addr, req_valid, flush, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_instr, rsp_addr, rsp_err, rsp_valid
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding an
// in-order response FIFO. Requests are only accepted while a FIFO slot is
// reserved for them (credit count), so responses can never be dropped.
module imem_responder #(
  parameter int WIDTH     = 32,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AW    = $clog2(RSP_DEPTH);
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  logic [WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             req_err;
  logic             wr_ok;
  logic             req_ready_int;
  logic             accept;
  logic             push;
  logic             pop;
  logic             empty;

  logic [CW-1:0]    credit;

  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_err;
  logic [WIDTH-1:0]   pipe_instr [LATENCY];
  logic [WIDTH-1:0]   pipe_addr  [LATENCY];

  logic [WIDTH-1:0] fifo_instr [RSP_DEPTH];
  logic [WIDTH-1:0] fifo_addr  [RSP_DEPTH];
  logic             fifo_err   [RSP_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW-1:0]    head;

  // Address decode for fetch and preload ports
  always_comb begin
    req_idx = bus.req_addr[IDX_W+1:2];
    wr_idx  = bus.wr_addr[IDX_W+1:2];
    req_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (IDX_W + 2)) != '0);
    wr_ok   = (bus.wr_addr[1:0] == 2'b00) && ((bus.wr_addr >> (IDX_W + 2)) == '0);
  end

  // Handshake qualifiers; ready depends only on the registered credit count
  always_comb begin
    req_ready_int = credit < CW'(RSP_DEPTH);
    accept        = bus.req_valid && req_ready_int && !bus.flush;
    empty         = (wptr == rptr);
    push          = pipe_vld[LATENCY-1] && !bus.flush;
    pop           = !empty && bus.rsp_ready && !bus.flush;
    head          = rptr[AW-1:0];
  end

  // Preload write port (array is never reset)
  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      mem[wr_idx] <= bus.wr_data;
    end
  end

  // Control state: pipeline valids, credit count, FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      credit   <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else if (bus.flush) begin
      pipe_vld <= '0;
      credit   <= '0;
      rptr     <= wptr;
    end else begin
      pipe_vld[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Read pipeline datapath; the array read uses pre-write contents
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_addr[0]  <= bus.req_addr;
      pipe_err[0]   <= req_err;
      pipe_instr[0] <= req_err ? '0 : mem[req_idx];
    end
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_addr[i]  <= pipe_addr[i-1];
      pipe_err[i]   <= pipe_err[i-1];
      pipe_instr[i] <= pipe_instr[i-1];
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wptr[AW-1:0]] <= pipe_instr[LATENCY-1];
      fifo_addr[wptr[AW-1:0]]  <= pipe_addr[LATENCY-1];
      fifo_err[wptr[AW-1:0]]   <= pipe_err[LATENCY-1];
    end
  end

  // Response outputs: FIFO head, forced to zero when empty
  always_comb begin
    bus.req_ready = req_ready_int;
    bus.rsp_valid = !empty;
    bus.rsp_instr = '0;
    bus.rsp_addr  = '0;
    bus.rsp_err   = 1'b0;
    if (!empty) begin
      bus.rsp_instr = fifo_instr[head];
      bus.rsp_addr  = fifo_addr[head];
      bus.rsp_err   = fifo_err[head];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder: a table of fetches
// streamed back-to-back, plus hand-written backpressure, flush,
// read-before-write and asynchronous-reset sequences.
module tb_imem_responder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  imem_responder_if #(.WIDTH(32)) bus ();

  imem_responder #(
    .WIDTH(32),
    .MEM_WORDS(1024),
    .LATENCY(2),
    .RSP_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Holds req_valid high with rsp_ready=0 and counts how many get accepted
  task automatic count_accepts(output int n);
    logic take;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = '0;
    for (int c = 0; c < 10; c++) begin
      take = bus.req_ready;
      step();
      if (take) begin
        n++;
        bus.req_addr = 32'(n * 4);
      end
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   nacc;
    int   idx;
    logic exp_v;

    n_cmp = 0;
    n_bad = 0;

    tbl[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
    tbl[3] = '{32'h0000_000C, 32'h0000_006F, 1'b0};
    tbl[4] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
    tbl[6] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0};
    tbl[7] = '{32'h0000_0007, 32'h0000_0000, 1'b1};

    rst_n         = 1'b0;
    bus.req_addr  = '0;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    #12 rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_instr", bus.rsp_instr, 0);
    chk("rst_rsp_addr",  bus.rsp_addr,  0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_req_ready", bus.req_ready, 1);

    // Preload, then two writes that must be dropped (out of range, misaligned)
    write_word(32'h0000_0000, 32'h0050_0093);
    write_word(32'h0000_0004, 32'h00A0_0113);
    write_word(32'h0000_0008, 32'h0020_81B3);
    write_word(32'h0000_000C, 32'h0000_006F);
    write_word(32'h0000_0FFC, 32'hDEAD_BEEF);
    write_word(32'h0000_1000, 32'hBAD0_BAD0);
    write_word(32'h0000_0006, 32'h1234_5678);
    step();

    // Back-to-back stream; response k must be visible exactly at cycle k+3
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      idx   = c - 3;
      exp_v = (idx >= 0) && (idx < 8);
      chk("stream_valid", bus.rsp_valid, exp_v);
      chk("stream_req_ready", bus.req_ready, 1);
      if (exp_v) begin
        chk("stream_instr", bus.rsp_instr, tbl[idx].instr);
        chk("stream_addr",  bus.rsp_addr,  tbl[idx].addr);
        chk("stream_err",   bus.rsp_err,   tbl[idx].err);
      end else begin
        chk("idle_instr", bus.rsp_instr, 0);
        chk("idle_addr",  bus.rsp_addr,  0);
        chk("idle_err",   bus.rsp_err,   0);
      end
      if (c < 8) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = tbl[c].addr;
      end else begin
        bus.req_valid = 1'b0;
      end
      step();
    end

    // Backpressure: exactly RSP_DEPTH accepts, head stable while stalled
    bus.rsp_ready = 1'b0;
    count_accepts(nacc);
    chk("bp_accepts", nacc, 4);
    chk("bp_req_ready_low", bus.req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_head_valid", bus.rsp_valid, 1);
      chk("bp_head_addr",  bus.rsp_addr,  32'h0);
      chk("bp_head_instr", bus.rsp_instr, 32'h0050_0093);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_pop_req_ready", bus.req_ready, 1);
    chk("bp_pop_head_addr", bus.rsp_addr,  32'h4);
    chk("bp_pop_head_instr", bus.rsp_instr, 32'h00A0_0113);
    step();
    chk("bp_hold_head_addr", bus.rsp_addr, 32'h4);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_drain_addr", bus.rsp_addr, 32'(4 * (c + 1)));
      step();
    end
    chk("bp_drained_valid", bus.rsp_valid, 0);

    // Flush mid-flight: 0x0 dropped, 0x4 masked, only 0x8 returns
    for (int c = 0; c < 9; c++) begin
      if (c >= 1) begin
        chk("flush_valid", bus.rsp_valid, (c == 5));
        if (c == 5) begin
          chk("flush_addr",  bus.rsp_addr,  32'h8);
          chk("flush_instr", bus.rsp_instr, 32'h0020_81B3);
        end
      end
      bus.req_valid = (c < 3);
      bus.req_addr  = 32'(4 * c);
      bus.flush     = (c == 1);
      step();
    end
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;

    // Read-before-write on the same word in the same cycle
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'h8;
    bus.wr_data   = 32'h1111_1111;
    step();
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    step();
    chk("rbw_not_yet", bus.rsp_valid, 0);
    step();
    chk("rbw_valid", bus.rsp_valid, 1);
    chk("rbw_old_data", bus.rsp_instr, 32'h0020_81B3);
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("rbw_new_valid", bus.rsp_valid, 1);
    chk("rbw_new_data", bus.rsp_instr, 32'h1111_1111);
    step();
    chk("rbw_empty", bus.rsp_valid, 0);

    // Asynchronous reset with three entries queued
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * c);
      step();
    end
    bus.req_valid = 1'b0;
    step();
    step();
    chk("ar_pre_valid", bus.rsp_valid, 1);
    chk("ar_pre_ready", bus.req_ready, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid_now", bus.rsp_valid, 0);
    chk("ar_instr_now", bus.rsp_instr, 0);
    chk("ar_addr_now",  bus.rsp_addr,  0);
    #2 rst_n = 1'b1;
    step();
    chk("ar_post_ready", bus.req_ready, 1);
    chk("ar_post_valid", bus.rsp_valid, 0);
    count_accepts(nacc);
    chk("ar_credits_cleared", nacc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
